// File: rtl/valet_pkg.sv
// Shared types and helpers for the valet score ledger: tip event encoding,
// the default-configuration history entry layout and delta signing/scaling.
package valet_pkg;

    typedef enum logic [1:0] {
        EvNone    = 2'b00,
        EvReward  = 2'b01,
        EvPenalty = 2'b10,
        EvBonus   = 2'b11
    } tip_event_t;

    localparam int unsigned DeltaCalcW = 64;

    // Entry layout for the default configuration (4 valets, 16-bit tips, shift 1, 32-bit time)
    typedef struct packed {
        logic [1:0]  valet_id;
        logic [17:0] delta;
        logic [31:0] time_stamp;
    } hist_entry_t;

    // Wide two's-complement result; callers truncate to their applied-delta width
    function automatic logic [DeltaCalcW-1:0] applied_delta(
        input tip_event_t             ev,
        input logic [DeltaCalcW-1:0]  mag,
        input int unsigned            shift
    );
        logic [DeltaCalcW-1:0] res;
        case (ev)
            EvReward:  res = mag;
            EvPenalty: res = -mag;
            EvBonus:   res = mag << shift;
            default:   res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/valet_hist_fifo.sv
// First-word fall-through history FIFO with optional overwrite-oldest behaviour
// when a push arrives while full and nothing is being popped.
module valet_hist_fifo
    import valet_pkg::*;
#(
    parameter int unsigned Depth     = 16,
    parameter type         entry_t   = logic [7:0],
    parameter bit          Overwrite = 1'b0,
    localparam int unsigned PtrW     = $clog2(Depth),
    localparam int unsigned CntW     = $clog2(Depth) + 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  entry_t          wdata_i,
    input  logic            pop_i,
    output logic            valid_o,
    output entry_t          head_o,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            overflow_o
);

    entry_t            mem_q [Depth];
    logic [PtrW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              pop, push_ok, drop;

    assign full_o     = (cnt_q == CntW'(Depth));
    assign valid_o    = (cnt_q != '0);
    assign head_o     = mem_q[rd_q];
    assign count_o    = cnt_q;
    assign overflow_o = ovf_q;

    assign pop     = pop_i && valid_o;
    assign push_ok = push_i && (!full_o || pop || Overwrite);
    // Full, pushing and not popping: the write lands on the head slot, so retire it
    assign drop    = push_ok && full_o && !pop;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (push_ok) begin
            wr_d = wr_q + PtrW'(1);
        end
        if (pop || drop) begin
            rd_d = rd_q + PtrW'(1);
        end
        if (push_ok && !pop && !drop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!push_ok && pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/valet_score_ledger.sv
// Per-valet signed saturating score ledger with clear arbitration, registered
// readback and a history log of every accepted, in-range tip event.
module valet_score_ledger
    import valet_pkg::*;
#(
    parameter int unsigned NUM_VALETS  = 4,
    parameter int unsigned DELTA_W     = 16,
    parameter int unsigned SCORE_W     = 32,
    parameter int unsigned TIME_W      = 32,
    parameter int unsigned HIST_DEPTH  = 16,
    parameter int unsigned BONUS_SHIFT = 1,
    parameter int unsigned HIST_MODE   = 0,
    localparam int unsigned ID_W  = (NUM_VALETS > 1) ? $clog2(NUM_VALETS) : 1,
    localparam int unsigned AD_W  = DELTA_W + BONUS_SHIFT + 1,
    localparam int unsigned CNT_W = $clog2(HIST_DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ID_W-1:0]           in_valet_id,
    input  tip_event_t                in_event,
    input  logic [DELTA_W-1:0]        in_delta,
    input  logic [TIME_W-1:0]         in_time,
    input  logic                      clr_valid,
    input  logic [ID_W-1:0]           clr_id,
    input  logic [ID_W-1:0]           score_sel,
    output logic signed [SCORE_W-1:0] score_out,
    output logic [NUM_VALETS-1:0]     sat_flag,
    output logic                      hist_valid,
    input  logic                      hist_ready,
    output logic [ID_W-1:0]           hist_valet_id,
    output logic signed [AD_W-1:0]    hist_delta,
    output logic [TIME_W-1:0]         hist_time,
    output logic [CNT_W-1:0]          hist_count,
    output logic                      hist_overflow
);

    typedef struct packed {
        logic [ID_W-1:0]   valet_id;
        logic [AD_W-1:0]   delta;
        logic [TIME_W-1:0] time_stamp;
    } entry_t;

    // One guard bit above the wider operand so the sum never wraps before clamping
    localparam int unsigned SUM_W = ((SCORE_W > AD_W) ? SCORE_W : AD_W) + 1;
    localparam logic [SUM_W-1:0] ScoreMax = {{(SUM_W-SCORE_W+1){1'b0}}, {(SCORE_W-1){1'b1}}};
    localparam logic [SUM_W-1:0] ScoreMin = {{(SUM_W-SCORE_W+1){1'b1}}, {(SCORE_W-1){1'b0}}};

    logic [SCORE_W-1:0]    score_q [NUM_VALETS];
    logic [SCORE_W-1:0]    score_d [NUM_VALETS];
    logic [NUM_VALETS-1:0] sat_q, sat_d;
    logic [SCORE_W-1:0]    score_out_q, score_out_d;
    logic [AD_W-1:0]       ad;
    logic [SUM_W-1:0]      sum;
    logic                  in_id_ok, clr_id_ok, sel_ok;
    logic                  in_accept, push, hist_full;
    entry_t                push_entry, head;

    assign ad        = AD_W'(applied_delta(in_event, DeltaCalcW'(in_delta), BONUS_SHIFT));
    assign in_id_ok  = 32'(in_valet_id) < NUM_VALETS;
    assign clr_id_ok = 32'(clr_id) < NUM_VALETS;
    assign sel_ok    = 32'(score_sel) < NUM_VALETS;
    assign in_ready  = (HIST_MODE != 0) ? 1'b1 : !hist_full;
    assign in_accept = in_valid && in_ready;
    assign push      = in_accept && in_id_ok;

    assign push_entry = '{valet_id: in_valet_id, delta: ad, time_stamp: in_time};

    always_comb begin
        score_d = score_q;
        sat_d   = sat_q;
        sum     = '0;
        if (push) begin
            sum = {{(SUM_W-SCORE_W){score_q[in_valet_id][SCORE_W-1]}}, score_q[in_valet_id]}
                + {{(SUM_W-AD_W){ad[AD_W-1]}}, ad};
            if ($signed(sum) > $signed(ScoreMax)) begin
                score_d[in_valet_id] = ScoreMax[SCORE_W-1:0];
                sat_d[in_valet_id]   = 1'b1;
            end else if ($signed(sum) < $signed(ScoreMin)) begin
                score_d[in_valet_id] = ScoreMin[SCORE_W-1:0];
                sat_d[in_valet_id]   = 1'b1;
            end else begin
                score_d[in_valet_id] = sum[SCORE_W-1:0];
            end
        end
        // Clear is applied last so it wins over a same-cycle event to the same valet
        if (clr_valid && clr_id_ok) begin
            score_d[clr_id] = '0;
            sat_d[clr_id]   = 1'b0;
        end
    end

    assign score_out_d = sel_ok ? score_q[score_sel] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q     <= '{default: '0};
            sat_q       <= '0;
            score_out_q <= '0;
        end else begin
            score_q     <= score_d;
            sat_q       <= sat_d;
            score_out_q <= score_out_d;
        end
    end

    assign score_out = score_out_q;
    assign sat_flag  = sat_q;

    valet_hist_fifo #(
        .Depth     (HIST_DEPTH),
        .entry_t   (entry_t),
        .Overwrite (HIST_MODE != 0)
    ) u_hist (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .wdata_i    (push_entry),
        .pop_i      (hist_ready),
        .valid_o    (hist_valid),
        .head_o     (head),
        .count_o    (hist_count),
        .full_o     (hist_full),
        .overflow_o (hist_overflow)
    );

    assign hist_valet_id = head.valet_id;
    assign hist_delta    = head.delta;
    assign hist_time     = head.time_stamp;

endmodule

// File: tb/tb_valet_score_ledger.sv
// Bench for valet_score_ledger: default stall-mode instance plus a 16-bit-score,
// 5-valet overwrite-mode instance, each with its own history scoreboard.
module tb_valet_score_ledger;
    import valet_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A: defaults, stall mode
    logic        a_in_valid, a_in_ready, a_clr_valid, a_hv, a_hr, a_ho;
    logic [1:0]  a_in_id, a_clr_id, a_sel, a_hid;
    tip_event_t  a_ev;
    logic [15:0] a_mag;
    logic [31:0] a_time, a_score, a_ht;
    logic [3:0]  a_sat;
    logic [17:0] a_hd;
    logic [4:0]  a_hc;

    // Instance B: 5 valets, 16-bit score, overwrite mode
    logic        b_in_valid, b_in_ready, b_clr_valid, b_hv, b_hr, b_ho;
    logic [2:0]  b_in_id, b_clr_id, b_sel, b_hid;
    tip_event_t  b_ev;
    logic [15:0] b_mag, b_score;
    logic [31:0] b_time, b_ht;
    logic [4:0]  b_sat;
    logic [17:0] b_hd;
    logic [4:0]  b_hc;

    valet_score_ledger u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_valet_id(a_in_id), .in_event(a_ev), .in_delta(a_mag), .in_time(a_time),
        .clr_valid(a_clr_valid), .clr_id(a_clr_id), .score_sel(a_sel), .score_out(a_score),
        .sat_flag(a_sat), .hist_valid(a_hv), .hist_ready(a_hr), .hist_valet_id(a_hid),
        .hist_delta(a_hd), .hist_time(a_ht), .hist_count(a_hc), .hist_overflow(a_ho)
    );

    valet_score_ledger #(.NUM_VALETS(5), .SCORE_W(16), .HIST_MODE(1)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_valet_id(b_in_id), .in_event(b_ev), .in_delta(b_mag), .in_time(b_time),
        .clr_valid(b_clr_valid), .clr_id(b_clr_id), .score_sel(b_sel), .score_out(b_score),
        .sat_flag(b_sat), .hist_valid(b_hv), .hist_ready(b_hr), .hist_valet_id(b_hid),
        .hist_delta(b_hd), .hist_time(b_ht), .hist_count(b_hc), .hist_overflow(b_ho)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [2:0]  id;
        logic [17:0] d;
        logic [31:0] t;
    } ent_t;
    ent_t qa[$];
    ent_t qb[$];

    typedef struct {
        logic [1:0]  id;
        tip_event_t  ev;
        logic [15:0] mag;
        logic [31:0] exp_score;
    } vec_t;
    vec_t        tbl[7];
    logic [31:0] prev_a[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] exp_ad(input tip_event_t ev, input logic [15:0] mag);
        int v;
        case (ev)
            EvReward:  v = int'(mag);
            EvPenalty: v = -int'(mag);
            EvBonus:   v = int'(mag) * 2;
            default:   v = 0;
        endcase
        return 18'(v);
    endfunction

    always @(negedge clk) begin : mon_a
        ent_t e;
        if (!rst) begin
            if (a_hv && a_hr) begin
                if (qa.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL a_hist_extra: got entry time %0d expected none", a_ht);
                end else begin
                    e = qa.pop_front();
                    chk("a_hist_id", 64'(a_hid), 64'(e.id));
                    chk("a_hist_delta", 64'(a_hd), 64'(e.d));
                    chk("a_hist_time", 64'(a_ht), 64'(e.t));
                end
            end
            if (a_in_valid && a_in_ready) begin
                qa.push_back('{id: {1'b0, a_in_id}, d: exp_ad(a_ev, a_mag), t: a_time});
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ent_t e;
        bit   popped;
        if (!rst) begin
            popped = 1'b0;
            if (b_hv && b_hr) begin
                popped = 1'b1;
                if (qb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL b_hist_extra: got entry time %0d expected none", b_ht);
                end else begin
                    e = qb.pop_front();
                    chk("b_hist_id", 64'(b_hid), 64'(e.id));
                    chk("b_hist_delta", 64'(b_hd), 64'(e.d));
                    chk("b_hist_time", 64'(b_ht), 64'(e.t));
                end
            end
            if (b_in_valid && b_in_ready && b_in_id < 3'd5) begin
                if (!popped && qb.size() == 16) void'(qb.pop_front());
                qb.push_back('{id: b_in_id, d: exp_ad(b_ev, b_mag), t: b_time});
            end
        end
    end

    task automatic drain_a;
        int n = 0;
        a_hr = 1'b1;
        while (a_hc != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("a_drain", 64'(a_hc), 64'(0));
    endtask

    task automatic drain_b;
        int n = 0;
        b_hr = 1'b1;
        while (b_hc != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("b_drain", 64'(b_hc), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        a_in_valid = 0; a_in_id = 0; a_ev = EvNone; a_mag = 0; a_time = 0;
        a_clr_valid = 0; a_clr_id = 0; a_sel = 0; a_hr = 1;
        b_in_valid = 0; b_in_id = 0; b_ev = EvNone; b_mag = 0; b_time = 0;
        b_clr_valid = 0; b_clr_id = 0; b_sel = 0; b_hr = 1;
        for (int i = 0; i < 4; i++) prev_a[i] = '0;

        tbl[0] = '{2'd2, EvReward,  16'd100,   32'd100};
        tbl[1] = '{2'd1, EvPenalty, 16'd30,    32'hFFFF_FFE2};
        tbl[2] = '{2'd1, EvBonus,   16'd10,    32'hFFFF_FFF6};
        tbl[3] = '{2'd0, EvReward,  16'd5,     32'd5};
        tbl[4] = '{2'd0, EvNone,    16'd77,    32'd5};
        tbl[5] = '{2'd3, EvPenalty, 16'hFFFF,  32'hFFFF_0001};
        tbl[6] = '{2'd3, EvBonus,   16'hFFFF,  32'h0000_FFFF};

        repeat (3) tick();
        rst = 1'b0;

        chk("a_rst_score", 64'(a_score), 64'(0));
        chk("a_rst_sat", 64'(a_sat), 64'(0));
        chk("a_rst_count", 64'(a_hc), 64'(0));
        chk("a_rst_valid", 64'(a_hv), 64'(0));
        chk("a_rst_ready", 64'(a_in_ready), 64'(1));
        chk("a_rst_ovf", 64'(a_ho), 64'(0));
        chk("b_rst_count", 64'(b_hc), 64'(0));
        chk("b_rst_ready", 64'(b_in_ready), 64'(1));

        // Table: one event per vector, readback checked one and two edges after accept
        for (int i = 0; i < 7; i++) begin
            a_in_valid = 1'b1;
            a_in_id    = tbl[i].id;
            a_ev       = tbl[i].ev;
            a_mag      = tbl[i].mag;
            a_time     = 32'(100 + i);
            a_sel      = tbl[i].id;
            tick();
            a_in_valid = 1'b0;
            chk("a_score_lat1", 64'(a_score), 64'(prev_a[tbl[i].id]));
            tick();
            chk("a_score", 64'(a_score), 64'(tbl[i].exp_score));
            prev_a[tbl[i].id] = tbl[i].exp_score;
        end
        chk("a_sat_none", 64'(a_sat), 64'(0));

        // Stall mode: fill with no pops, hold a 17th, one pop frees one slot
        drain_a();
        a_hr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("a_ready_fill", 64'(a_in_ready), 64'(1));
            a_in_valid = 1'b1;
            a_in_id    = 2'(i % 4);
            a_ev       = EvReward;
            a_mag      = 16'd1;
            a_time     = 32'(1000 + i);
            tick();
        end
        a_time = 32'd1016;
        chk("a_full_count", 64'(a_hc), 64'(16));
        chk("a_full_ready", 64'(a_in_ready), 64'(0));
        repeat (2) tick();
        chk("a_held_count", 64'(a_hc), 64'(16));
        chk("a_held_ready", 64'(a_in_ready), 64'(0));
        a_hr = 1'b1;
        tick();
        a_hr = 1'b0;
        chk("a_pop_count", 64'(a_hc), 64'(15));
        chk("a_pop_ready", 64'(a_in_ready), 64'(1));
        tick();
        a_in_valid = 1'b0;
        chk("a_refill_count", 64'(a_hc), 64'(16));
        chk("a_refill_ready", 64'(a_in_ready), 64'(0));
        drain_a();

        // Saturation on 16-bit scores
        b_in_valid = 1'b1; b_in_id = 3'd0; b_ev = EvReward; b_mag = 16'hFFFF; b_sel = 3'd0;
        for (int i = 0; i < 3; i++) begin
            b_time = 32'(300 + i);
            tick();
        end
        b_in_valid = 1'b0;
        tick();
        chk("b_sat_pos_score", 64'(b_score), 64'(16'h7FFF));
        chk("b_sat_pos_flag", 64'(b_sat), 64'(5'b00001));
        b_in_valid = 1'b1; b_in_id = 3'd1; b_ev = EvPenalty; b_sel = 3'd1;
        for (int i = 0; i < 2; i++) begin
            b_time = 32'(310 + i);
            tick();
        end
        b_in_valid = 1'b0;
        tick();
        chk("b_sat_neg_score", 64'(b_score), 64'(16'h8000));
        chk("b_sat_neg_flag", 64'(b_sat), 64'(5'b00011));
        b_clr_valid = 1'b1; b_clr_id = 3'd0; b_sel = 3'd0;
        tick();
        b_clr_valid = 1'b0;
        chk("b_clr_lat1", 64'(b_score), 64'(16'h7FFF));
        tick();
        chk("b_clr_score", 64'(b_score), 64'(0));
        chk("b_clr_flag", 64'(b_sat), 64'(5'b00010));

        // Clear and event to the same valet in one cycle
        b_in_valid = 1'b1; b_in_id = 3'd3; b_ev = EvReward; b_mag = 16'd7; b_time = 32'd400;
        b_sel = 3'd3;
        tick();
        b_in_valid = 1'b0;
        tick();
        chk("b_pre_clr_score", 64'(b_score), 64'(7));
        b_in_valid = 1'b1; b_mag = 16'd50; b_time = 32'd401;
        b_clr_valid = 1'b1; b_clr_id = 3'd3;
        tick();
        b_in_valid = 1'b0; b_clr_valid = 1'b0;
        tick();
        chk("b_clr_wins", 64'(b_score), 64'(0));
        drain_b();

        // Out-of-range valet: accepted but neither scored nor logged
        b_in_valid = 1'b1; b_in_id = 3'd5; b_ev = EvReward; b_mag = 16'd9; b_time = 32'd500;
        chk("b_bad_id_ready", 64'(b_in_ready), 64'(1));
        tick();
        b_in_valid = 1'b0;
        chk("b_bad_id_count", 64'(b_hc), 64'(0));
        chk("b_bad_id_valid", 64'(b_hv), 64'(0));
        chk("b_bad_id_flag", 64'(b_sat), 64'(5'b00010));

        // Overwrite mode: 18 pushes with no pops drop the two oldest
        b_hr = 1'b0;
        for (int i = 0; i < 18; i++) begin
            b_in_valid = 1'b1;
            b_in_id    = 3'(i % 5);
            b_ev       = EvReward;
            b_mag      = 16'd1;
            b_time     = 32'(2000 + i);
            tick();
            if (i == 15) begin
                chk("b_full_count", 64'(b_hc), 64'(16));
                chk("b_full_no_ovf", 64'(b_ho), 64'(0));
            end
        end
        b_in_valid = 1'b0;
        chk("b_ovf_count", 64'(b_hc), 64'(16));
        chk("b_ovf_flag", 64'(b_ho), 64'(1));
        chk("b_ovf_head", 64'(b_ht), 64'(2002));
        chk("b_ovf_ready", 64'(b_in_ready), 64'(1));
        drain_b();

        tick();
        chk("a_queue_empty", 64'(qa.size()), 64'(0));
        chk("b_queue_empty", 64'(qb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
